// File: rtl/elevator_display_pkg.sv
// Shared definitions for the elevator LED display scanner.
// Holds the segment bit positions used on each digit, the all-off and
// all-on drive codes (the array is active-low), and a helper that builds
// the raw segment pattern of one digit before blinking or lamp test apply.
package elevator_display_pkg;

  // Segment bit positions within the 8-bit active-low digit drive
  localparam int SEG_FLOOR_HI  = 7;
  localparam int SEG_FLOOR_MID = 6;
  localparam int SEG_DIR       = 4;
  localparam int SEG_FLOOR_LO  = 2;
  localparam int SEG_IDLE      = 1;

  localparam logic [7:0] LED_ALL_OFF = 8'hFF;
  localparam logic [7:0] LED_ALL_ON  = 8'h00;

  // Builds {f, f, 1, x, 1, f, idle|f, 1}. A 0 lights the segment, so a
  // digit that is not the current floor (f=1) keeps its floor and idle
  // marks dark. Bits 5, 3 and 0 are never used and stay dark.
  function automatic logic [7:0] digitPattern(input logic notFloor,
                                              input logic endSwitch,
                                              input logic idle);
    logic [7:0] p;
    p                = LED_ALL_OFF;
    p[SEG_FLOOR_HI]  = notFloor;
    p[SEG_FLOOR_MID] = notFloor;
    p[SEG_DIR]       = endSwitch;
    p[SEG_FLOOR_LO]  = notFloor;
    p[SEG_IDLE]      = idle | notFloor;
    return p;
  endfunction

endpackage

// File: rtl/elevator_display_scanner_prescaler.sv
// scan_prescaler: free-running divider that produces one tick every DIV
// clock cycles. Generic so any scanned display can reuse it.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, restarts the count at 0
//   tick  - high during the cycle where the count sits at DIV-1
module scan_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] divCnt_q;
  logic [CW-1:0] divCnt_d;

  // Count 0..DIV-1 and wrap; with DIV=1 the count is pinned at 0 and
  // the tick is asserted every cycle.
  always_comb begin
    divCnt_d = divCnt_q + CW'(1);
    if (divCnt_q == LAST) begin
      divCnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_d;
    end
  end

  assign tick = (divCnt_q == LAST);

endmodule

// File: rtl/elevator_display_scanner.sv
// elevator_display_scanner: multiplexes the elevator floor/status display
// onto a common-anode, active-low LED array, one digit per floor.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   floor         - current floor index (out-of-range lights no floor mark)
//   ues, les      - upper/lower end switches, shown raw on top digit / digit 0
//   is            - idle status, 1 keeps the idle mark dark
//   moving        - car moving, enables blinking of the floor indicator
//   lamp_test     - lights every segment of each scanned digit
//   led_sel       - active-low one-hot digit select, digit k on bit N-1-k
//   led_out       - active-low segment drive
//   frame_start   - one-cycle pulse in the cycle after digit 0 is loaded
module elevator_display_scanner
  import elevator_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  ues,
  input  logic                  les,
  input  logic                  is,
  input  logic                  moving,
  input  logic                  lamp_test,
  output logic [NUM_DIGITS-1:0] led_sel,
  output logic [7:0]            led_out,
  output logic                  frame_start
);

  localparam int            DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int            FCW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [FCW-1:0] LAST_FRAME = FCW'(BLINK_FRAMES - 1);

  logic                  tick;
  logic [DW-1:0]         digit_q, digit_d;
  logic [FCW-1:0]        frameCnt_q, frameCnt_d;
  logic                  blinkPhase_q, blinkPhase_d;
  logic                  scanning_q, scanning_d;
  logic [NUM_DIGITS-1:0] ledSel_q, ledSel_d;
  logic [7:0]            ledOut_q, ledOut_d;
  logic                  frameStart_q, frameStart_d;

  logic                  loadsZero;
  logic                  frameAdvance;
  logic                  frameWrap;
  logic                  notFloor;
  logic                  endSwitch;
  logic [7:0]            pattern;
  logic [NUM_DIGITS-1:0] selPattern;

  scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // digit_q names the digit the next tick will load, so the first tick
  // after reset loads digit 0. The first digit-0 load only opens frame 0;
  // later digit-0 loads each close a completed frame and advance the blink
  // counter. The blink phase used for the pattern is the post-update
  // value, so a whole frame shares one phase. Priority of the segment
  // drive is lamp test over blink over the normal pattern.
  always_comb begin
    digit_d      = digit_q;
    frameCnt_d   = frameCnt_q;
    blinkPhase_d = blinkPhase_q;
    scanning_d   = scanning_q;
    ledSel_d     = ledSel_q;
    ledOut_d     = ledOut_q;
    frameStart_d = 1'b0;

    loadsZero    = (digit_q == '0);
    frameAdvance = tick && loadsZero && scanning_q;
    frameWrap    = frameAdvance && (frameCnt_q == LAST_FRAME);

    if (frameWrap) begin
      frameCnt_d   = '0;
      blinkPhase_d = ~blinkPhase_q;
    end else if (frameAdvance) begin
      frameCnt_d = frameCnt_q + FCW'(1);
    end

    notFloor = (int'(floor) != int'(digit_q));
    if (NUM_DIGITS == 1) begin
      endSwitch = les & ues;
    end else if (digit_q == '0) begin
      endSwitch = les;
    end else if (digit_q == LAST_DIGIT) begin
      endSwitch = ues;
    end else begin
      endSwitch = 1'b0;
    end

    pattern = digitPattern(notFloor, endSwitch, is);
    if (moving && blinkPhase_d) begin
      pattern[SEG_FLOOR_HI]  = 1'b1;
      pattern[SEG_FLOOR_MID] = 1'b1;
      pattern[SEG_FLOOR_LO]  = 1'b1;
      pattern[SEG_IDLE]      = 1'b1;
    end
    if (lamp_test) begin
      pattern = LED_ALL_ON;
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      selPattern[NUM_DIGITS-1-k] = (int'(digit_q) != k);
    end

    if (tick) begin
      ledSel_d     = selPattern;
      ledOut_d     = pattern;
      frameStart_d = loadsZero;
      scanning_d   = 1'b1;
      digit_d      = (digit_q == LAST_DIGIT) ? '0 : digit_q + DW'(1);
    end
  end

  // State and output registers; reset returns the display to dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q      <= '0;
      frameCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      scanning_q   <= 1'b0;
      ledSel_q     <= '1;
      ledOut_q     <= LED_ALL_OFF;
      frameStart_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      frameCnt_q   <= frameCnt_d;
      blinkPhase_q <= blinkPhase_d;
      scanning_q   <= scanning_d;
      ledSel_q     <= ledSel_d;
      ledOut_q     <= ledOut_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign led_sel     = ledSel_q;
  assign led_out     = ledOut_q;
  assign frame_start = frameStart_q;

endmodule
